xout_rr_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one registered 8-bit output register (XOUT) among NREQ requesters.
- Each requester presents a request and a data byte. The arbiter grants one requester per cycle, loads its byte into XOUT, and acknowledges it.
- Sits in front of XOUT-style consumer blocks, replacing per-block ad-hoc writes with a fair, single-writer path.

---
 rtl/arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 38 +++
 rtl/xout_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_xout_rr_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the XOUT round-robin arbiter.
// Exports: arb_state_t, DEF_NREQ, DEF_WIDTH, id_w().
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    LOCKED
  } arb_state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of elig at or after ptr.
// Ports: elig (eligible mask), ptr (search start) -> any, g (winner).
module rr_pick
  import arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = id_w(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   g
);

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] sh;
  logic [NREQ-1:0]   rot;
  logic [IW-1:0]     k;
  logic [IW:0]       sum;

  always_comb begin
    dbl = {elig, elig};
    sh  = dbl >> ptr;
    rot = sh[NREQ-1:0];
    any = |rot;
    k   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) k = IW'(i);
    end
    // Undo the rotation; explicit modulo keeps non-power-of-2 NREQ legal.
    sum = {1'b0, ptr} + {1'b0, k};
    if (sum >= (IW+1)'(NREQ)) begin
      sum = sum - (IW+1)'(NREQ);
    end
    g = sum[IW-1:0];
  end

endmodule

// File: rtl/xout_rr_arbiter.sv
// Round-robin arbiter sharing one registered XOUT among NREQ requesters.
// Ports: CLK, RESET(async low), REQ, DIN, [LOCK if ARB_LOCK_EN] ->
//        ACK, XOUT, XVALID, GRANT_ID.
module xout_rr_arbiter
  import arb_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = 15
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NREQ-1:0]         REQ,
  input  logic [NREQ*WIDTH-1:0]   DIN,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]         LOCK,
`endif
  output logic [NREQ-1:0]         ACK,
  output logic [WIDTH-1:0]        XOUT,
  output logic                    XVALID,
  output logic [$clog2(NREQ)-1:0] GRANT_ID
);

  localparam int IW = id_w(NREQ);

  arb_state_t       state_q, state_n;
  logic [IW-1:0]    ptr_q, ptr_n;
  logic [NREQ-1:0]  ack_q, ack_n;
  logic [WIDTH-1:0] xout_q, xout_n;
  logic             xv_q, xv_n;
  logic [IW-1:0]    gid_q, gid_n;

  logic [NREQ-1:0]  mask;
  logic [NREQ-1:0]  elig;
  logic             any;
  logic [IW-1:0]    g;
  logic             do_pick;
  logic [WIDTH-1:0] din_a [NREQ];

`ifdef ARB_LOCK_EN
  localparam int CW = id_w(MAX_HOLD + 1);
  logic [CW-1:0] cnt_q, cnt_n;
`endif

  function automatic logic [IW-1:0] inc(
    input logic [IW-1:0] x
  );
    return (x == IW'(NREQ - 1)) ? '0 : x + IW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      din_a[i] = DIN[i*WIDTH +: WIDTH];
    end
  end

  // An outstanding ACK masks its owner for one cycle.
  always_comb begin
    mask = '0;
    if (state_q != IDLE) mask = ack_q;
    elig = REQ & ~mask;
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .elig (elig),
    .ptr  (ptr_q),
    .any  (any),
    .g    (g)
  );

  always_comb begin
    state_n = IDLE;
    ptr_n   = ptr_q;
    ack_n   = '0;
    xout_n  = xout_q;
    xv_n    = 1'b0;
    gid_n   = gid_q;
    do_pick = 1'b1;
`ifdef ARB_LOCK_EN
    cnt_n   = '0;
    if (state_q == LOCKED) begin
      if (REQ[gid_q] && LOCK[gid_q] &&
          cnt_q != CW'(MAX_HOLD)) begin
        do_pick = 1'b0;
        state_n = LOCKED;
        ack_n   = NREQ'(1) << gid_q;
        xout_n  = din_a[gid_q];
        xv_n    = 1'b1;
        cnt_n   = cnt_q + CW'(1);
      end else begin
        ptr_n = inc(gid_q);
      end
    end
`endif
    if (do_pick && any) begin
      state_n = GRANT;
      ptr_n   = inc(g);
      ack_n   = NREQ'(1) << g;
      xout_n  = din_a[g];
      xv_n    = 1'b1;
      gid_n   = g;
`ifdef ARB_LOCK_EN
      if (LOCK[g]) state_n = LOCKED;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ack_q   <= '0;
      xout_q  <= '0;
      xv_q    <= 1'b0;
      gid_q   <= '0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      ack_q   <= ack_n;
      xout_q  <= xout_n;
      xv_q    <= xv_n;
      gid_q   <= gid_n;
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) cnt_q <= '0;
    else        cnt_q <= cnt_n;
  end
`endif

  assign ACK      = ack_q;
  assign XOUT     = xout_q;
  assign XVALID   = xv_q;
  assign GRANT_ID = gid_q;

endmodule

// File: tb/tb_xout_rr_arbiter.sv
// Self-checking bench for xout_rr_arbiter against a behavioural model.
// Covers reset, single/fair/wrap grants, async reset, random, lock.
module tb_xout_rr_arbiter;

  localparam int MH = 3;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [3:0]  REQ = '0;
  logic [31:0] DIN = '0;
  logic [3:0]  LOCK = '0;
  logic [3:0]  ACK;
  logic [7:0]  XOUT;
  logic        XVALID;
  logic [1:0]  GRANT_ID;

  int errors = 0;
  int checks = 0;

  int         m_ptr, m_ack, m_gid, m_hold, m_own;
  bit         m_locked, m_valid;
  logic [7:0] m_xout;

  always #5 CLK = ~CLK;

  xout_rr_arbiter #(
    .NREQ     (4),
    .WIDTH    (8),
    .MAX_HOLD (MH)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .REQ      (REQ),
    .DIN      (DIN),
`ifdef ARB_LOCK_EN
    .LOCK     (LOCK),
`endif
    .ACK      (ACK),
    .XOUT     (XOUT),
    .XVALID   (XVALID),
    .GRANT_ID (GRANT_ID)
  );

  task automatic model_reset;
    m_ptr = 0; m_ack = -1; m_gid = 0; m_hold = 0;
    m_own = 0; m_locked = 0; m_valid = 0; m_xout = '0;
  endtask

  // One clock edge worth of arbitration rules, from current inputs.
  task automatic model_step;
    int g, idx;
    g = -1;
    if (m_locked && REQ[m_own] && LOCK[m_own] && m_hold < MH) begin
      g = m_own;
      m_hold++;
    end else begin
      if (m_locked) begin
        m_ptr = (m_own + 1) % 4;
        m_locked = 0;
        m_hold = 0;
      end
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (g < 0 && REQ[idx] && m_ack != idx) g = idx;
      end
      if (g >= 0) begin
        m_ptr = (g + 1) % 4;
        if (LOCK[g]) begin
          m_locked = 1; m_own = g; m_hold = 0;
        end
      end
    end
    if (g >= 0) begin
      m_ack = g; m_gid = g; m_valid = 1;
      m_xout = DIN[g*8 +: 8];
    end else begin
      m_ack = -1; m_valid = 0;
    end
  endtask

  function automatic logic [3:0] exp_ack();
    return (m_ack < 0) ? 4'b0000 : 4'(1 << m_ack);
  endfunction

  task automatic step;
    model_step;
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset;
    RESET = 1'b0;
    REQ = '0;
    LOCK = '0;
    #2;
    RESET = 1'b1;
    model_reset;
  endtask

  task automatic test_reset;
    RESET = 1'b0;
    REQ = 4'b1111;
    DIN = 32'h44332211;
    model_reset;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (ACK !== 4'b0 || XVALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack ack=%b xv=%b want 0/0", ACK, XVALID);
    end
    checks++;
    if (XOUT !== 8'h00 || GRANT_ID !== 2'd0) begin
      errors++;
      $display("FAIL reset_out xout=%h gid=%0d want 00/0", XOUT, GRANT_ID);
    end
    RESET = 1'b1;
    step;
    checks++;
    if (ACK !== 4'b0001 || GRANT_ID !== 2'd0) begin
      errors++;
      $display("FAIL reset_first ack=%b gid=%0d want 0001/0", ACK, GRANT_ID);
    end
    checks++;
    if (XOUT !== 8'h11 || XVALID !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_x xout=%h xv=%b want 11/1", XOUT, XVALID);
    end
  endtask

  task automatic test_single;
    REQ = 4'b0100;
    DIN = 32'h00A50000;
    step;
    checks++;
    if (ACK !== 4'b0100 || XOUT !== 8'hA5 || GRANT_ID !== 2'd2) begin
      errors++;
      $display("FAIL single_grant ack=%b xout=%h gid=%0d want 0100/a5/2",
               ACK, XOUT, GRANT_ID);
    end
    step;
    checks++;
    if (ACK !== 4'b0 || XVALID !== 1'b0 || XOUT !== 8'hA5) begin
      errors++;
      $display("FAIL single_mask ack=%b xv=%b xout=%h want 0/0/a5",
               ACK, XVALID, XOUT);
    end
    step;
    checks++;
    if (ACK !== 4'b0100 || XVALID !== 1'b1) begin
      errors++;
      $display("FAIL single_regrant ack=%b xv=%b want 0100/1", ACK, XVALID);
    end
  endtask

  task automatic test_fairness;
    int ord[5] = '{0, 1, 2, 3, 0};
    apply_reset;
    REQ = 4'b1111;
    DIN = 32'h13121110;
    for (int i = 0; i < 5; i++) begin
      step;
      checks++;
      if (GRANT_ID !== 2'(ord[i]) || ACK !== 4'(1 << ord[i]) ||
          XOUT !== 8'h10 + 8'(ord[i])) begin
        errors++;
        $display("FAIL fair_%0d gid=%0d ack=%b xout=%h want %0d",
                 i, GRANT_ID, ACK, XOUT, ord[i]);
      end
    end
  endtask

  task automatic test_wrap;
    int ord[3] = '{0, 1, 2};
    apply_reset;
    DIN = 32'hD3C2B1A0;
    REQ = 4'b0100;
    step;
    REQ = 4'b0011;
    step;
    step;
    REQ = 4'b1111;
    step;
    checks++;
    if (GRANT_ID !== 2'(ord[2]) || ACK !== 4'b0100) begin
      errors++;
      $display("FAIL wrap_ptr gid=%0d ack=%b want 2/0100", GRANT_ID, ACK);
    end
  endtask

  task automatic test_wrap_seq;
    apply_reset;
    DIN = 32'hD3C2B1A0;
    REQ = 4'b0100;
    step;
    REQ = 4'b0011;
    step;
    checks++;
    if (GRANT_ID !== 2'd0 || XOUT !== 8'hA0) begin
      errors++;
      $display("FAIL wrap_first gid=%0d xout=%h want 0/a0", GRANT_ID, XOUT);
    end
    step;
    checks++;
    if (GRANT_ID !== 2'd1 || XOUT !== 8'hB1) begin
      errors++;
      $display("FAIL wrap_second gid=%0d xout=%h want 1/b1", GRANT_ID, XOUT);
    end
  endtask

  task automatic test_async_reset;
    apply_reset;
    REQ = 4'b0010;
    DIN = 32'h44332211;
    step;
    checks++;
    if (ACK !== 4'b0010) begin
      errors++;
      $display("FAIL async_pre ack=%b want 0010", ACK);
    end
    #2;
    RESET = 1'b0;
    model_reset;
    #1;
    checks++;
    if (ACK !== 4'b0 || XOUT !== 8'h00 || XVALID !== 1'b0 ||
        GRANT_ID !== 2'd0) begin
      errors++;
      $display("FAIL async_clear ack=%b xout=%h xv=%b gid=%0d want 0",
               ACK, XOUT, XVALID, GRANT_ID);
    end
    #1;
    RESET = 1'b1;
    REQ = 4'b1111;
    step;
    checks++;
    if (GRANT_ID !== 2'd0 || ACK !== 4'b0001) begin
      errors++;
      $display("FAIL async_ptr gid=%0d ack=%b want 0/0001", GRANT_ID, ACK);
    end
  endtask

  task automatic test_random;
    apply_reset;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (m_ack == i || !REQ[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            REQ[i] = 1'b1;
            DIN[i*8 +: 8] = 8'($urandom);
          end else begin
            REQ[i] = 1'b0;
          end
        end
      end
`ifdef ARB_LOCK_EN
      LOCK = 4'($urandom) & 4'($urandom);
`endif
      step;
      checks++;
      if (ACK !== exp_ack() || XVALID !== m_valid) begin
        errors++;
        $display("FAIL rand_ack c=%0d ack=%b xv=%b want %b/%b",
                 c, ACK, XVALID, exp_ack(), m_valid);
      end
      checks++;
      if (XOUT !== m_xout || GRANT_ID !== 2'(m_gid)) begin
        errors++;
        $display("FAIL rand_out c=%0d xout=%h gid=%0d want %h/%0d",
                 c, XOUT, GRANT_ID, m_xout, m_gid);
      end
      checks++;
      if ($countones(ACK) > 1) begin
        errors++;
        $display("FAIL rand_onehot c=%0d ack=%b want <=1 bit", c, ACK);
      end
    end
    REQ = '0;
    LOCK = '0;
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock;
    int ord[5] = '{1, 1, 1, 1, 0};
    apply_reset;
    DIN = 32'h44332211;
    REQ = 4'b0001;
    step;
    REQ = 4'b0011;
    LOCK = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      step;
      checks++;
      if (GRANT_ID !== 2'(ord[i]) || ACK !== 4'(1 << ord[i]) ||
          XVALID !== 1'b1) begin
        errors++;
        $display("FAIL lock_%0d gid=%0d ack=%b xv=%b want %0d",
                 i, GRANT_ID, ACK, XVALID, ord[i]);
      end
    end
    LOCK = '0;
    REQ = '0;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_wrap_seq;
    test_wrap;
    test_async_reset;
`ifdef ARB_LOCK_EN
    test_lock;
`endif
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
